bus_fifo: RTL and testbench
===========================

// Module: bus_fifo
// PURPOSE
//   Elastic buffer on the bus_if valid/ready channel, directly downstream of bus_mux.
//   Absorbs master-side backpressure so the arbitrated winner completes and grant is released early.
//   Stores up to DEPTH beats in order; exposes fill-level status for flow monitoring.
// PARAMETERS
//   DATA_WIDTH  32  width of bus_if.data; must equal the bus_if instance parameter
//   DEPTH       4   number of storage entries; power of two, >= 2
// PORTS
//   i_clk          input   1                   single clock; all state on its rising edge
//   i_rst          input   1                   reset: synchronous and active-high
//   slave_if       bus_if.slave  -             upstream channel (valid/data in, ready out)
//   master_if      bus_if.master -             downstream channel (valid/data out, ready in)
//   o_count        output  $clog2(DEPTH)+1     entries currently stored, 0..DEPTH
//   o_full         output  1                   o_count == DEPTH
//   o_empty        output  1                   o_count == 0
// BEHAVIOUR
//   - Clock is i_clk; reset is i_rst, synchronous and active-high. All other timing is relative to i_clk.
//   - Reset (i_rst high at an edge): wr_ptr=0, rd_ptr=0, count=0 -> o_empty=1, o_full=0, o_count=0,
//     master_if.valid=0. slave_if.ready=0 while i_rst is high.
//     Reset mid-operation discards all stored beats; no partial beat is ever emitted.
//   - push = slave_if.valid && slave_if.ready; pop = master_if.valid && master_if.ready.
//   - slave_if.ready = !o_full && !i_rst. It does not depend on master_if.ready, so there is no
//     combinational ready path from master to slave.
//   - master_if.valid = !o_empty; master_if.data = mem[rd_ptr].
//     Data is stable while valid && !ready (AXI-style hold rule).
//   - push: mem[wr_ptr] <= slave_if.data; wr_ptr <= wr_ptr+1. Wraps modulo DEPTH, natural overflow.
//   - pop: rd_ptr <= rd_ptr+1, wrapping the same way.
//   - count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
//   - Latency: a beat written at edge N is visible on master_if at cycle N+1 (1-cycle minimum).
//   - Full: a push is impossible because ready=0. A pop while full re-asserts ready in the next cycle.
//   - Empty: a pop is impossible because valid=0. A push while empty makes valid=1 in the next cycle.
//   - Simultaneous push and pop at count==1 or count==DEPTH-1: both take effect, count is unchanged.
//   - Throughput: sustained 1 beat/cycle with both sides ready and 0 < count < DEPTH.
//   - Assertions (sim only):
//       count <= DEPTH;
//       no push while full;
//       master_if.data stable while valid && !ready.
// CONFIGURATION
//   BUS_FIFO_CUT_THROUGH_EN
//     defined:
//       - When o_empty, master_if.valid = slave_if.valid and master_if.data = slave_if.data (0-cycle path).
//       - If master_if.ready is also high, the beat passes through without being written:
//         pointers and count are unchanged.
//       - When not empty, behaviour is identical to the undefined case.
//       - Adds a combinational valid/data path, slave -> master.
//     undefined:
//       - Fully registered boundary on valid/data.
//       - Minimum latency is 1 cycle.
// STRUCTURE
//   - bus_pkg (shared): DATA_WIDTH default constant and typedef logic [DATA_WIDTH-1:0] bus_data_t.
//     bus_mux and bus_fifo use the same type.
//   - Local: ptr width localparam PTR_W = $clog2(DEPTH).
//   - Sub-module bus_fifo_ram: DEPTH x DATA_WIDTH flop array.
//     Ports: i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
//     Asynchronous read; no reset on the contents.
//   - Top-level holds the pointers, count, handshake logic and the cut-through mux.
// TESTING
//   1. Reset: hold i_rst for 3 cycles with slave valid=1
//      -> ready=0, master valid=0, o_count=0, o_empty=1 throughout.
//   2. Fill: master ready=0, push 0xA0..0xA3 (DEPTH=4)
//      -> o_count 1,2,3,4; o_full=1 after the 4th push; ready=0 and the 5th beat (0xA4) stays held.
//   3. Drain: from full, master ready=1
//      -> outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; ready=1 one cycle after the first pop;
//         o_empty=1 after the last pop.
//   4. Streaming: both sides ready, 16 beats 0x00..0x0F
//      -> output in order, 1 beat/cycle after 1 cycle of latency;
//         o_count held at 1 with push and pop simultaneous.
//   5. Wrap and backpressure: random master ready (seeded) over 100 beats
//      -> scoreboard order matches; pointers wrap at least 20 times; data is stable while stalled.
//   6. Mid-operation reset: with 3 beats stored, pulse i_rst for 1 cycle
//      -> o_count=0 next cycle, no stale beat is emitted, and the next pushed value 0x55 is the first output.
//      With BUS_FIFO_CUT_THROUGH_EN defined, an empty FIFO with both sides ready passes 0x77 on the same cycle
//      and o_count stays 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions used by bus_mux and bus_fifo: default data width and beat type.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 32;

  typedef logic [BUS_DATA_WIDTH-1:0] bus_data_t;

endpackage

// File: rtl/bus_if.sv
// Valid/ready beat channel; master drives valid/data, slave drives ready.
interface bus_if #(
  parameter int DATA_WIDTH = bus_pkg::BUS_DATA_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/bus_fifo_chk.sv
// Simulation-only protocol checks for bus_fifo: fill bound, overflow and output hold rule.
module bus_fifo_chk #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  input logic [CNT_W-1:0]      i_count,
  input logic                  i_full,
  input logic                  i_s_valid,
  input logic                  i_s_ready,
  input logic                  i_m_valid,
  input logic                  i_m_ready,
  input logic [DATA_WIDTH-1:0] i_m_data
);

  a_count_bound : assert property (@(posedge i_clk) disable iff (i_rst)
    i_count <= CNT_W'(DEPTH));

  a_no_push_full : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_s_valid && i_s_ready && i_full));

  a_hold_stalled : assert property (@(posedge i_clk) disable iff (i_rst)
    (i_m_valid && !i_m_ready) |=> (i_m_valid && (i_m_data == $past(i_m_data))));

endmodule

// File: rtl/bus_fifo_ram.sv
// DEPTH x DATA_WIDTH storage for bus_fifo: synchronous write, asynchronous read, contents never reset.
module bus_fifo_ram
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port: one beat per cycle when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_r[i_raddr];

endmodule

// File: rtl/bus_fifo.sv
// Elastic valid/ready buffer downstream of bus_mux with fill-level status.
// Define BUS_FIFO_CUT_THROUGH_EN to let a beat bypass storage when the FIFO is empty.
module bus_fifo
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  bus_if.slave                   slave_if,
  bus_if.master                  master_if,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_next_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;

  // Ready never looks at master_if.ready, so no combinational path runs master -> slave.
  assign slave_if.ready = !full_r && !i_rst;
  assign push_s         = slave_if.valid && slave_if.ready;
  assign pop_s          = master_if.valid && master_if.ready;

`ifdef BUS_FIFO_CUT_THROUGH_EN
  // Empty FIFO forwards the upstream beat; if taken at once it never touches storage.
  assign master_if.valid = empty_r ? (slave_if.valid && !i_rst) : 1'b1;
  assign master_if.data  = empty_r ? slave_if.data : ram_rdata_s;
  assign wr_en_s         = push_s && !(empty_r && master_if.ready);
  assign rd_en_s         = pop_s && !empty_r;
`else
  assign master_if.valid = !empty_r;
  assign master_if.data  = ram_rdata_s;
  assign wr_en_s         = push_s;
  assign rd_en_s         = pop_s;
`endif

  // Next fill level from the storage-side write/read enables.
  always_comb begin
    count_next_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, fill level and registered status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(DEPTH));
      empty_r <= (count_next_s == {CNT_W{1'b0}});
    end
  end

  assign o_count = count_r;
  assign o_full  = full_r;
  assign o_empty = empty_r;

  bus_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en_s),
    .i_waddr (wr_ptr_r),
    .i_wdata (slave_if.data),
    .i_raddr (rd_ptr_r),
    .o_rdata (ram_rdata_s)
  );

  bus_fifo_chk #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_chk (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_count   (count_r),
    .i_full    (full_r),
    .i_s_valid (slave_if.valid),
    .i_s_ready (slave_if.ready),
    .i_m_valid (master_if.valid),
    .i_m_ready (master_if.ready),
    .i_m_data  (master_if.data)
  );

endmodule

// File: tb/tb_bus_fifo.sv
// Bench for bus_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_bus_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  bus_if #(.DATA_WIDTH(DW)) up_if ();
  bus_if #(.DATA_WIDTH(DW)) dn_if ();

  bus_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .slave_if  (up_if),
    .master_if (dn_if),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] out_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the FIFO is a queue of at most DEPTH beats; checked mid-cycle, advanced per edge.
  always @(negedge clk) begin
    bit            exp_ready;
    bit            exp_valid;
    bit            push;
    bit            pop;
    logic [DW-1:0] exp_data;
    exp_ready = !rst && (q.size() < DEPTH);
`ifdef BUS_FIFO_CUT_THROUGH_EN
    exp_valid = (q.size() != 0) || (up_if.valid && !rst);
    exp_data  = (q.size() != 0) ? q[0] : up_if.data;
`else
    exp_valid = (q.size() != 0);
    exp_data  = (q.size() != 0) ? q[0] : '0;
`endif
    check("ready", 64'(up_if.ready), 64'(exp_ready));
    check("valid", 64'(dn_if.valid), 64'(exp_valid));
    check("count", 64'(count), 64'(q.size()));
    check("full",  64'(full),  64'(q.size() == DEPTH));
    check("empty", 64'(empty), 64'(q.size() == 0));
    if (exp_valid) check("data", 64'(dn_if.data), 64'(exp_data));
    push = up_if.valid && exp_ready;
    pop  = exp_valid && dn_if.ready;
    if (pop) out_log.push_back(dn_if.data);
    if (rst) begin
      q.delete();
    end else if (q.size() == 0 && push && pop) begin
      // beat passed straight through; nothing stored
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(up_if.data);
        pushes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;
    int p0;
    logic [DW-1:0] v;
    void'($urandom(32'd20240611));

    // Reset held with upstream valid
    rst = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = 32'hDEAD_BEEF;
    dn_if.ready = 1'b0;
    repeat (3) cycle();
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    rst = 1'b0;

    // Fill with master stalled; fifth beat must be held off
    for (int i = 0; i < 5; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 32'hA0 + 32'(i);
      cycle();
      if (i < 4) check("fill_count", 64'(count), 64'(i + 1));
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(up_if.ready), 64'd0);
    check("fill_count_held", 64'(count), 64'd4);

    // Drain
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    out_log.delete();
    cycle();
    check("drain_ready", 64'(up_if.ready), 64'd1);
    repeat (3) cycle();
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_n", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < out_log.size() && i < 4; i++) begin
      v = 32'hA0 + 32'(i);
      check("drain_data", 64'(out_log[i]), 64'(v));
    end

    // Streaming 16 beats with both sides ready
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 32'(i);
      cycle();
`ifndef BUS_FIFO_CUT_THROUGH_EN
      check("stream_count", 64'(count), 64'd1);
`endif
    end
    up_if.valid = 1'b0;
    repeat (2) cycle();
    check("stream_n", 64'(out_log.size()), 64'd16);
    for (int i = 0; i < out_log.size() && i < 16; i++) begin
      check("stream_data", 64'(out_log[i]), 64'(i));
    end

    // Random backpressure over 100 beats
    out_log.delete();
    beats = 0;
    p0 = pushes;
    for (int c = 0; c < 3000 && beats < 100; c++) begin
      up_if.valid = ($urandom_range(0, 3) != 0);
      up_if.data  = $urandom;
      dn_if.ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (up_if.valid && up_if.ready) beats++;
      cycle();
    end
    check("rand_beats", 64'(beats), 64'd100);
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    for (int i = 0; i < 20 && !empty; i++) cycle();
    check("rand_drained", 64'(empty), 64'd1);
    check("rand_out_n", 64'(out_log.size()), 64'd100);
`ifndef BUS_FIFO_CUT_THROUGH_EN
    check("rand_wraps", 64'((pushes - p0) >= 20 * DEPTH), 64'd1);
`endif

    // Mid-operation reset with three beats stored
    dn_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 32'h31 + 32'(i);
      cycle();
    end
    up_if.valid = 1'b0;
    check("mid_count3", 64'(count), 64'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_count0", 64'(count), 64'd0);
    check("mid_empty", 64'(empty), 64'd1);
    check("mid_valid", 64'(dn_if.valid), 64'd0);
    out_log.delete();
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = 32'h55;
    cycle();
    up_if.valid = 1'b0;
    repeat (3) cycle();
    check("mid_out_n", 64'(out_log.size()), 64'd1);
    if (out_log.size() > 0) check("mid_first", 64'(out_log[0]), 64'h55);

`ifdef BUS_FIFO_CUT_THROUGH_EN
    // Same-cycle pass-through on an empty FIFO
    up_if.valid = 1'b1;
    up_if.data  = 32'h77;
    #1;
    check("ct_valid", 64'(dn_if.valid), 64'd1);
    check("ct_data", 64'(dn_if.data), 64'h77);
    cycle();
    up_if.valid = 1'b0;
    check("ct_count", 64'(count), 64'd0);
`endif

    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
